// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared state encoding and constants for the byte-stream loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// Module : byte_packer
// Brief  : Assembles little-endian 32-bit words from accepted bytes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] w_next;

    // Only three bytes need storing; the fourth completes the word in flight.
    assign w_next       = {i_byte, r_shift};
    assign o_word       = w_next;
    assign o_word_valid = i_accept && (r_cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_accept) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= w_next[31:8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module : prog_loader
// Brief  : Framed byte-stream program loader driving the core load port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        rom_wen,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_word_cnt;
    logic [IDX_W-1:0] r_word_idx;
    logic [31:0]      r_acc;

    logic             w_accept;
    logic             w_clr;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic [IDX_W-1:0] w_idx_next;

    assign w_accept   = in_valid && in_ready;
    assign w_clr      = start && ((r_state == DONE) || (r_state == ERR));
    assign w_idx_next = r_word_idx + IDX_W'(1);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clr        (w_clr),
        .i_accept     (w_accept),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HDR;
            in_ready   <= 1'b1;
            rom_wen    <= 1'b0;
            rom_addr   <= 32'd0;
            rom_wdata  <= 32'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            r_word_cnt <= '0;
            r_word_idx <= '0;
            r_acc      <= 32'd0;
        end else begin
            rom_wen <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_word_valid) begin
                        r_word_cnt <= w_word[IDX_W-1:0];
                        if (w_word > MAX_WORDS) begin
                            r_state  <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (w_word == 32'd0) begin
                            r_state <= CKSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_state   <= WRITE;
                        rom_wen   <= 1'b1;
                        rom_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
                        rom_wdata <= w_word;
                        in_ready  <= 1'b0;
                    end
                end
                WRITE: begin
                    // Checksum folds in the word just written as the strobe retires.
                    r_acc      <= r_acc ^ rom_wdata;
                    r_word_idx <= w_idx_next;
                    in_ready   <= 1'b1;
                    r_state    <= (w_idx_next < r_word_cnt) ? DATA : CKSUM;
                end
                CKSUM: begin
                    if (w_word_valid) begin
                        in_ready <= 1'b0;
                        if (w_word == r_acc) begin
                            r_state    <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        r_state    <= HDR;
                        in_ready   <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        r_word_cnt <= '0;
                        r_word_idx <= '0;
                        r_acc      <= 32'd0;
                    end
                end
                default: begin
                    r_state <= HDR;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module : tb_prog_loader
// Brief  : Randomised self-checking bench for prog_loader with a frame model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          MAXW = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .rom_wen    (rom_wen),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          rand_valid = 1'b0;
    bit          rand_start = 1'b0;
    logic [7:0]  frame[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_consumed;
    int          exp_writes;
    bit          exp_done;
    int          wen_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Per-cycle checks against the queued expectations from the frame model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("core_reset_vs_done", core_reset, !done);
            if (rom_wen) begin
                wen_count++;
                check("in_ready_during_write", in_ready, 0);
                if (exp_addr.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_wen: addr %h data %h, required no write", rom_addr, rom_wdata);
                end else begin
                    check("rom_addr", rom_addr, exp_addr.pop_front());
                    check("rom_wdata", rom_wdata, exp_data.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] word_at(input int k);
        return {frame[k+3], frame[k+2], frame[k+1], frame[k]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) frame.push_back(w[8*b +: 8]);
    endtask

    // Frame rules: header N, N words written at BASE+4i, then XOR checksum.
    task automatic run_model();
        logic [31:0] n;
        logic [31:0] acc;
        exp_addr.delete();
        exp_data.delete();
        wen_count = 0;
        n = word_at(0);
        if (n > MAXW) begin
            exp_done     = 1'b0;
            exp_consumed = 4;
            exp_writes   = 0;
            return;
        end
        acc = 32'd0;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(word_at(4 + 4 * i));
            acc ^= word_at(4 + 4 * i);
        end
        exp_writes   = int'(n);
        exp_done     = (word_at(4 + 4 * int'(n)) == acc);
        exp_consumed = 8 + 4 * int'(n);
    endtask

    task automatic send_bytes(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int  waited = 0;
            bit  taken  = 1'b0;
            while (!taken) begin
                @(negedge clk);
                in_data  = frame[i];
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                start    = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
                taken    = in_valid && in_ready;
                waited++;
                if (!taken && waited > 40) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL byte_accept_timeout: byte %0d not accepted, required within 40 cycles", i);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_frame();
        int w = 0;
        while (!(done || err) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("done", done, exp_done);
        check("err", err, !exp_done);
        check("core_reset_end", core_reset, !exp_done);
        check("in_ready_end", in_ready, 0);
        check("wen_count", wen_count, exp_writes);
        check("writes_left", exp_addr.size(), 0);
    endtask

    task automatic rearm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_in_ready", in_ready, 1);
        check("rearm_core_reset", core_reset, 1);
        check("rearm_done", done, 0);
        check("rearm_err", err, 0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_rom_wen", rom_wen, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_wdata", rom_wdata, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic load_good_image();
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                  8'h73, 8'h00, 8'h10, 8'h00, 8'h60, 8'h05, 8'h00, 8'h00};
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check_reset_values();

        // Normal two-word image; literals pin the model too.
        load_good_image();
        run_model();
        check("pin_writes", exp_addr.size(), 2);
        check("pin_addr0", exp_addr[0], 32'h8000_0000);
        check("pin_data0", exp_data[0], 32'h0010_0513);
        check("pin_addr1", exp_addr[1], 32'h8000_0004);
        check("pin_data1", exp_data[1], 32'h0010_0073);
        check("pin_done", exp_done, 1);
        send_bytes(exp_consumed);
        finish_frame();
        rearm();

        // Bad checksum.
        load_good_image();
        frame[15] = 8'h01;
        run_model();
        check("pin_bad_done", exp_done, 0);
        send_bytes(exp_consumed);
        finish_frame();
        rearm();

        // Oversize header 4097.
        frame = '{8'h01, 8'h10, 8'h00, 8'h00};
        run_model();
        check("pin_over_consumed", exp_consumed, 4);
        send_bytes(exp_consumed);
        finish_frame();
        rearm();

        // Empty image under random backpressure.
        frame.delete();
        push_word(32'd0);
        push_word(32'd0);
        run_model();
        check("pin_empty_done", exp_done, 1);
        rand_valid = 1'b1;
        send_bytes(exp_consumed);
        finish_frame();
        rearm();

        // Reset after the second data byte, then a full image.
        load_good_image();
        exp_addr.delete();
        exp_data.delete();
        rand_valid = 1'b0;
        send_bytes(6);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values();
        repeat (3) @(negedge clk);
        rand_valid = 1'b1;
        run_model();
        send_bytes(exp_consumed);
        finish_frame();
        rearm();

        // Random images with stray start pulses, occasional corruption/oversize.
        rand_start = 1'b1;
        for (int it = 0; it < 10; it++) begin
            int          nw;
            logic [31:0] acc;
            logic [31:0] w;
            frame.delete();
            nw = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) push_word(32'(MAXW + 1 + $urandom_range(0, 1000)));
            else push_word(32'(nw));
            acc = 32'd0;
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                push_word(w);
                acc ^= w;
            end
            if ($urandom_range(0, 2) == 0) acc ^= (32'd1 << $urandom_range(0, 31));
            push_word(acc);
            run_model();
            send_bytes(exp_consumed);
            finish_frame();
            rearm();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
